line_buf_ctrl: RTL and testbench
================================

# line_buf_ctrl

Line-delay controller for the convolution filter front end. Takes the pixel stream (data enable, vsync, 8-bit pixel) and sequences an internal single-port RAM as a one-line delay: each cycle it writes the incoming pixel and reads back the pixel from the same column of the previous line. It emits both pixels aligned, with a validity flag for the "above" pixel. Two instances in series provide the three vertically adjacent taps of the 3x3 window.

## Interface

Parameters:
- DATA_W, 8: pixel width.
- ADDR_W, 11: RAM address width; maximum line length is 2^ADDR_W pixels.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_de  in  1  data enable; one pixel per cycle while high.
- in_vs  in  1  vsync; frame restart while high.
- in_pix  in  DATA_W  incoming pixel.
- out_valid  out  1  output pixel pair valid.
- out_cur  out  DATA_W  current-line pixel, delayed one cycle.
- out_above  out  DATA_W  pixel from the same column of the previous line.
- out_above_ok  out  1  out_above holds real data from this frame.
- out_col  out  ADDR_W+1  column index of the output pair.
- line_len  out  ADDR_W+1  length of the last completed line.
- overflow  out  1  sticky flag: a line exceeded 2^ADDR_W pixels in this frame.

## Operation

- Registers:
  - col: ADDR_W+1 bits, column counter.
  - prev_len: ADDR_W+1 bits, drives line_len.
  - de_d: in_de delayed one cycle.
  - overflow: sticky flag.
- Frame restart (in_vs=1): col←0, prev_len←0, overflow←0, no RAM access, out_valid←0. in_de is ignored in these cycles. in_vs has priority over every other event.
- Pixel cycle (in_vs=0, in_de=1):
  - If col < 2^ADDR_W: RAM en=1, we=1, addr=col[ADDR_W-1:0], din=in_pix; col←col+1.
  - Otherwise: en=0, pixel dropped, overflow←1, col holds.
- The RAM is read-first, so the read on a write cycle returns the previous line's pixel at that column.
- End of line (in_vs=0, in_de=0, de_d=1): prev_len←col, col←0. An in_de rising edge in the following cycle starts a new line normally.
- Idle (in_de=0, de_d=0): RAM en=0; no register changes.
- Output stage, registered one cycle after each pixel cycle:
  - out_valid=1 only for pixels that were written.
  - out_cur=in_pix.
  - out_col=col before increment.
  - out_above_ok=(col < prev_len), evaluated at the pixel cycle.
  - out_above=RAM dout.
  - Dropped pixels produce out_valid=0.
- The first line of a frame always has out_above_ok=0, because prev_len=0. A line longer than its predecessor has out_above_ok=0 for columns ≥ prev_len.
- When out_above_ok=0, out_above is don't-care. Consumers must substitute their own border value.

## Timing

- Latency: pixel sampled at edge t → out_* valid after edge t+1. Throughput is one pixel per cycle with no stalls and no backpressure.
- line_len updates on the edge following the in_de falling edge.
- Reset (rst=1, synchronous): col, prev_len, de_d, overflow, out_valid, out_above_ok, out_col, out_cur, line_len all ←0. out_above follows RAM dout, which is not reset.
- Reset asserted mid-line: the line is discarded, and the next line is treated as the first line of a frame.
- in_vs and an in_de falling edge in the same cycle: frame restart wins, so prev_len=0.
- Overflow line of N > 2^ADDR_W pixels: the first 2^ADDR_W pixels are output, and line_len=2^ADDR_W.

## Structure

- Shared filter package holds:
  - DATA_W and ADDR_W defaults.
  - the border policy constant (BORDER_PIX=0), used by window consumers.
- One sub-module: sp_ram (2^ADDR_W × DATA_W, read-first, registered output, en/we) instantiated inside. All addressing, enables and alignment stay in line_buf_ctrl.
- Everything else is about 150 lines of counter, edge-detect and output-pipeline logic.

## Test plan

- Reset, then one line of 4 pixels (10,20,30,40): out_valid for 4 cycles; out_cur=10,20,30,40; out_col=0..3; out_above_ok=0; line_len=4 after the fall.
- Second line 11,21,31,41: out_above=10,20,30,40 with out_above_ok=1; out_cur=11,21,31,41.
- Line of 3 followed by a line of 5: columns 0–2 have out_above_ok=1, columns 3–4 have out_above_ok=0.
- in_vs pulse between lines, then a line: out_above_ok=0 throughout; line_len=0 during vs.
- ADDR_W=2 with a 6-pixel line: 4 outputs, overflow=1, line_len=4. Overflow clears on the next in_vs.
- rst asserted mid-line at column 2: all outputs 0 next cycle; the following line has out_above_ok=0.

Source files
------------

// File: rtl/line_buf_ctrl_pkg.sv
// Shared filter front-end definitions: default widths, border policy and the
// per-cycle event classification used by the line-delay controller.
package line_buf_ctrl_pkg;

    localparam int LBC_DATA_W = 8;
    localparam int LBC_ADDR_W = 11;
    localparam int BORDER_PIX = 0;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_FRAME,
        CYC_PIX,
        CYC_EOL
    } cyc_e;

    // vsync beats everything, then an active pixel, then the de falling edge.
    function automatic cyc_e classify(input logic vs, input logic de, input logic de_d);
        if (vs)
            return CYC_FRAME;
        if (de)
            return CYC_PIX;
        if (de_d)
            return CYC_EOL;
        return CYC_IDLE;
    endfunction

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Pixel-stream in / aligned pixel-pair out bundle of the line-delay controller.
interface line_buf_ctrl_if
    import line_buf_ctrl_pkg::*;
#(
    parameter int DATA_W = LBC_DATA_W,
    parameter int ADDR_W = LBC_ADDR_W
) ();

    logic              in_de;
    logic              in_vs;
    logic [DATA_W-1:0] in_pix;
    logic              out_valid;
    logic [DATA_W-1:0] out_cur;
    logic [DATA_W-1:0] out_above;
    logic              out_above_ok;
    logic [ADDR_W:0]   out_col;
    logic [ADDR_W:0]   line_len;
    logic              overflow;

    modport master (
        output in_de, in_vs, in_pix,
        input  out_valid, out_cur, out_above, out_above_ok, out_col, line_len, overflow
    );

    modport slave (
        input  in_de, in_vs, in_pix,
        output out_valid, out_cur, out_above, out_above_ok, out_col, line_len, overflow
    );

endinterface

// File: rtl/line_buf_ctrl_sp_ram.sv
// Single-port line RAM: read-first, registered output that only updates on en.
module sp_ram
    import line_buf_ctrl_pkg::*;
#(
    parameter int DATA_W = LBC_DATA_W,
    parameter int ADDR_W = LBC_ADDR_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] dout_q;

    // The read samples the old word, so a write cycle returns last line's pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= din;
            dout_q <= mem[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// One-line delay controller: writes each pixel into the line RAM while reading
// the same column of the previous line, and emits both pixels aligned.
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter int DATA_W = LBC_DATA_W,
    parameter int ADDR_W = LBC_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    line_buf_ctrl_if.slave bus
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LINE_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     prev_len_q, prev_len_d;
    logic              de_d_q, de_d_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;
    logic              out_above_ok_q, out_above_ok_d;
    logic [CW-1:0]     out_col_q, out_col_d;
    logic [DATA_W-1:0] out_cur_q, out_cur_d;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    cyc_e              cyc;
    logic              has_room;

    always_comb begin
        cyc            = classify(bus.in_vs, bus.in_de, de_d_q);
        has_room       = (col_q < LINE_MAX);
        col_d          = col_q;
        prev_len_d     = prev_len_q;
        de_d_d         = bus.in_de;
        overflow_d     = overflow_q;
        out_valid_d    = 1'b0;
        out_above_ok_d = 1'b0;
        out_col_d      = out_col_q;
        out_cur_d      = out_cur_q;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = col_q[ADDR_W-1:0];
        ram_din        = bus.in_pix;

        unique case (cyc)
            CYC_FRAME: begin
                // in_de is ignored during vsync, so no falling edge survives it
                col_d      = '0;
                prev_len_d = '0;
                overflow_d = 1'b0;
                de_d_d     = 1'b0;
            end
            CYC_PIX: begin
                if (has_room) begin
                    ram_en         = 1'b1;
                    ram_we         = 1'b1;
                    col_d          = col_q + 1'b1;
                    out_valid_d    = 1'b1;
                    out_cur_d      = bus.in_pix;
                    out_col_d      = col_q;
                    out_above_ok_d = (col_q < prev_len_q);
                end else begin
                    overflow_d = 1'b1;
                end
            end
            CYC_EOL: begin
                prev_len_d = col_q;
                col_d      = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q          <= '0;
            prev_len_q     <= '0;
            de_d_q         <= 1'b0;
            overflow_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_above_ok_q <= 1'b0;
            out_col_q      <= '0;
            out_cur_q      <= '0;
        end else begin
            col_q          <= col_d;
            prev_len_q     <= prev_len_d;
            de_d_q         <= de_d_d;
            overflow_q     <= overflow_d;
            out_valid_q    <= out_valid_d;
            out_above_ok_q <= out_above_ok_d;
            out_col_q      <= out_col_d;
            out_cur_q      <= out_cur_d;
        end
    end

    sp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk (clk),
        .en  (ram_en),
        .we  (ram_we),
        .addr(ram_addr),
        .din (ram_din),
        .dout(ram_dout)
    );

    assign bus.out_valid    = out_valid_q;
    assign bus.out_cur      = out_cur_q;
    assign bus.out_above    = ram_dout;
    assign bus.out_above_ok = out_above_ok_q;
    assign bus.out_col      = out_col_q;
    assign bus.line_len     = prev_len_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: a wide instance and a 4-pixel instance share one
// stimulus stream and are compared every cycle against a line-queue model.
module tb_line_buf_ctrl;
    import line_buf_ctrl_pkg::*;

    localparam int DW  = 8;
    localparam int AW0 = 11;
    localparam int AW1 = 2;
    localparam int NI  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       de  = 1'b0;
    logic       vs  = 1'b0;
    logic [7:0] pix = 8'd0;

    always #5 clk = ~clk;

    line_buf_ctrl_if #(.DATA_W(DW), .ADDR_W(AW0)) bus0 ();
    line_buf_ctrl_if #(.DATA_W(DW), .ADDR_W(AW1)) bus1 ();

    assign bus0.in_de  = de;
    assign bus0.in_vs  = vs;
    assign bus0.in_pix = pix;
    assign bus1.in_de  = de;
    assign bus1.in_vs  = vs;
    assign bus1.in_pix = pix;

    line_buf_ctrl #(.DATA_W(DW), .ADDR_W(AW0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    line_buf_ctrl #(.DATA_W(DW), .ADDR_W(AW1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model: current and previous line as arrays
    int cap [NI] = '{2 ** AW0, 2 ** AW1};
    int prev_n [NI];
    int cur_n [NI];
    int prev_pix [NI][2048];
    int cur_pix [NI][2048];
    bit in_line [NI];
    bit m_ovf [NI];
    bit e_valid [NI];
    bit e_ok [NI];
    bit e_rst [NI];
    int e_cur [NI];
    int e_col [NI];
    int e_above [NI];

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                e_valid[i] = 1'b0;
                e_ok[i]    = 1'b0;
                e_rst[i]   = 1'b0;
                if (rst) begin
                    prev_n[i] = 0; cur_n[i] = 0; m_ovf[i] = 1'b0; in_line[i] = 1'b0;
                    e_rst[i]  = 1'b1;
                end else if (vs) begin
                    prev_n[i] = 0; cur_n[i] = 0; m_ovf[i] = 1'b0; in_line[i] = 1'b0;
                end else if (de) begin
                    in_line[i] = 1'b1;
                    if (cur_n[i] < cap[i]) begin
                        e_valid[i] = 1'b1;
                        e_cur[i]   = int'(pix);
                        e_col[i]   = cur_n[i];
                        e_ok[i]    = cur_n[i] < prev_n[i];
                        if (e_ok[i])
                            e_above[i] = prev_pix[i][cur_n[i]];
                        cur_pix[i][cur_n[i]] = int'(pix);
                        cur_n[i]++;
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end else begin
                    if (in_line[i]) begin
                        for (int k = 0; k < cur_n[i]; k++)
                            prev_pix[i][k] = cur_pix[i][k];
                        prev_n[i] = cur_n[i];
                        cur_n[i]  = 0;
                    end
                    in_line[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- compare process (opposite edge) plus capture of dut0 pairs
    int cq_cur[$];
    int cq_above[$];
    int cq_ok[$];
    int cq_col[$];
    int cnt1 = 0;

    initial begin
        int a_valid [NI];
        int a_cur [NI];
        int a_above [NI];
        int a_ok [NI];
        int a_col [NI];
        int a_len [NI];
        int a_ovf [NI];
        forever begin
            @(negedge clk);
            a_valid[0] = int'(bus0.out_valid);    a_valid[1] = int'(bus1.out_valid);
            a_cur[0]   = int'(bus0.out_cur);      a_cur[1]   = int'(bus1.out_cur);
            a_above[0] = int'(bus0.out_above);    a_above[1] = int'(bus1.out_above);
            a_ok[0]    = int'(bus0.out_above_ok); a_ok[1]    = int'(bus1.out_above_ok);
            a_col[0]   = int'(bus0.out_col);      a_col[1]   = int'(bus1.out_col);
            a_len[0]   = int'(bus0.line_len);     a_len[1]   = int'(bus1.line_len);
            a_ovf[0]   = int'(bus0.overflow);     a_ovf[1]   = int'(bus1.overflow);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d out_valid", i), a_valid[i], int'(e_valid[i]));
                chk($sformatf("u%0d line_len", i), a_len[i], prev_n[i]);
                chk($sformatf("u%0d overflow", i), a_ovf[i], int'(m_ovf[i]));
                if (e_valid[i]) begin
                    chk($sformatf("u%0d out_cur", i), a_cur[i], e_cur[i]);
                    chk($sformatf("u%0d out_col", i), a_col[i], e_col[i]);
                    chk($sformatf("u%0d out_above_ok", i), a_ok[i], int'(e_ok[i]));
                    if (e_ok[i])
                        chk($sformatf("u%0d out_above col %0d", i, e_col[i]), a_above[i], e_above[i]);
                end
                if (e_rst[i]) begin
                    chk($sformatf("u%0d reset out_cur", i), a_cur[i], 0);
                    chk($sformatf("u%0d reset out_col", i), a_col[i], 0);
                    chk($sformatf("u%0d reset out_above_ok", i), a_ok[i], 0);
                end
            end
            if (bus0.out_valid) begin
                cq_cur.push_back(a_cur[0]);
                cq_above.push_back(a_above[0]);
                cq_ok.push_back(a_ok[0]);
                cq_col.push_back(a_col[0]);
            end
            if (bus1.out_valid)
                cnt1++;
        end
    end

    // ---------------- stimulus
    task automatic drive(input bit d, input bit v, input int p, input bit r);
        @(negedge clk);
        de  = d;
        vs  = v;
        pix = p[7:0];
        rst = r;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic send_line(input int n, input int base, input int step);
        for (int k = 0; k < n; k++)
            drive(1'b1, 1'b0, base + k * step, 1'b0);
    endtask

    task automatic clear_cap();
        cq_cur.delete();
        cq_above.delete();
        cq_ok.delete();
        cq_col.delete();
    endtask

    initial begin
        int ones;
        for (int k = 0; k < 3; k++)
            drive(1'b0, 1'b0, 0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b0);
        chk("lit reset line_len", int'(bus0.line_len), 0);
        chk("lit reset overflow", int'(bus0.overflow), 0);
        chk("lit reset out_valid", int'(bus0.out_valid), 0);

        // First line of the frame: no above data yet.
        clear_cap();
        send_line(4, 10, 10);
        idle(2);
        chk("lit line1 count", cq_cur.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lit line1 cur%0d", k), cq_cur[k], 10 + 10 * k);
            chk($sformatf("lit line1 col%0d", k), cq_col[k], k);
            chk($sformatf("lit line1 ok%0d", k), cq_ok[k], 0);
        end
        chk("lit line1 line_len", int'(bus0.line_len), 4);

        clear_cap();
        send_line(4, 11, 10);
        idle(2);
        chk("lit line2 count", cq_cur.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lit line2 cur%0d", k), cq_cur[k], 11 + 10 * k);
            chk($sformatf("lit line2 above%0d", k), cq_above[k], 10 + 10 * k);
            chk($sformatf("lit line2 ok%0d", k), cq_ok[k], 1);
        end

        // Short line then a longer one: columns past the short length lose above.
        clear_cap();
        send_line(3, 1, 1);
        idle(1);
        send_line(5, 100, 1);
        idle(2);
        chk("lit 3then5 count", cq_cur.size(), 8);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lit 3then5 col%0d", k), cq_col[3 + k], k);
            chk($sformatf("lit 3then5 ok%0d", k), cq_ok[3 + k], (k < 3) ? 1 : 0);
        end
        chk("lit 3then5 above0", cq_above[3], 1);

        drive(1'b0, 1'b1, 0, 1'b0);
        drive(1'b0, 1'b1, 0, 1'b0);
        chk("lit vs line_len", int'(bus0.line_len), 0);
        chk("lit vs overflow u1", int'(bus1.overflow), 0);
        idle(1);
        clear_cap();
        send_line(4, 50, 1);
        idle(2);
        ones = 0;
        foreach (cq_ok[k]) ones += cq_ok[k];
        chk("lit after vs ok count", ones, 0);
        chk("lit after vs count", cq_cur.size(), 4);

        // Overflow on the 4-pixel instance, cleared by the next vsync.
        drive(1'b0, 1'b1, 0, 1'b0);
        idle(1);
        cnt1 = 0;
        send_line(6, 200, 1);
        idle(2);
        chk("lit ovf outputs u1", cnt1, 4);
        chk("lit ovf flag u1", int'(bus1.overflow), 1);
        chk("lit ovf line_len u1", int'(bus1.line_len), 4);
        chk("lit ovf flag u0", int'(bus0.overflow), 0);
        chk("lit ovf line_len u0", int'(bus0.line_len), 6);
        drive(1'b0, 1'b1, 0, 1'b0);
        idle(1);
        chk("lit ovf cleared u1", int'(bus1.overflow), 0);

        // Reset in the middle of a line at column 2.
        send_line(4, 30, 1);
        idle(1);
        send_line(2, 60, 1);
        drive(1'b1, 1'b0, 62, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b0);
        chk("lit rst out_valid", int'(bus0.out_valid), 0);
        chk("lit rst out_cur", int'(bus0.out_cur), 0);
        chk("lit rst out_col", int'(bus0.out_col), 0);
        chk("lit rst out_above_ok", int'(bus0.out_above_ok), 0);
        chk("lit rst line_len", int'(bus0.line_len), 0);
        clear_cap();
        send_line(3, 70, 1);
        idle(2);
        ones = 0;
        foreach (cq_ok[k]) ones += cq_ok[k];
        chk("lit after rst ok count", ones, 0);
        chk("lit after rst count", cq_cur.size(), 3);

        // Random lines, gaps, vsync pulses (also on de falls) and rare resets.
        for (int n = 0; n < 400; n++) begin
            int len;
            int gap;
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++)
                drive(1'b1, ($urandom_range(0, 63) == 0), $urandom_range(0, 255),
                      ($urandom_range(0, 149) == 0));
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++)
                drive(1'b0, ($urandom_range(0, 7) == 0), 0, 1'b0);
        end
        idle(3);
        clear_cap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
